keypad_bcd_entry: RTL

- Operator-input end of the 3-digit BCD path.
- Scans a 4x4 active-low matrix keypad and debounces key presses.
- Builds a 3-digit BCD entry and commits it on an Enter key as a 12-bit number with a one-cycle valid strobe.
- Runs on the undivided board clock. Its outputs use the same 12-bit BCD format the display and timer blocks consume: digit2 in [11:8], digit1 in [7:4], digit0 in [3:0].

---
 rtl/keypad_bcd_entry.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_bcd_entry.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_bcd_entry
//  Purpose  : Scans a 4x4 active-low matrix keypad, debounces presses and
//             releases, builds a 3-digit BCD entry and commits it on Enter.
//  Ports    : clk        - board clock
//             rst_N      - asynchronous active-low reset
//             key_col    - keypad columns, active-low, asynchronous
//             key_row    - one-hot active-low row drive
//             entry_BCD  - digits being typed {d2,d1,d0}
//             digit_cnt  - number of digits held in entry_BCD (0..3)
//             number_BCD - last committed number
//             valid      - one-clk strobe when number_BCD is updated
//  Revision : 1.0 - initial release
// ============================================================================
module keypad_bcd_entry #(
    parameter int SCAN_DIV  = 50000,
    parameter int DEB_TICKS = 20
) (
    input  logic        clk,
    input  logic        rst_N,
    input  logic [3:0]  key_col,
    output logic [3:0]  key_row,
    output logic [11:0] entry_BCD,
    output logic [1:0]  digit_cnt,
    output logic [11:0] number_BCD,
    output logic        valid
);

    localparam int c_DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_DEB_W = $clog2(DEB_TICKS + 1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2
    } state_t;

    state_t               r_state, w_next_state;
    logic [3:0]           r_col_meta, r_col_s;
    logic [c_DIV_W-1:0]   r_div;
    logic                 w_tick;
    logic [1:0]           r_row;
    logic [3:0]           r_col_pat;
    logic [1:0]           r_col_idx;
    logic [c_DEB_W-1:0]   r_deb, w_deb_next, w_deb_inc;
    logic                 w_rotate, w_latch, w_event;
    logic                 w_one_low;
    logic [1:0]           w_col_idx, w_evt_col;
    logic                 w_is_digit, w_is_back, w_is_enter, w_is_clear;
    logic [3:0]           w_digit;
    logic [11:0]          r_entry, r_number;
    logic [1:0]           r_cnt;
    logic                 r_valid;

    // Two-flop synchronizer; idle level is all-ones (no key).
    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            r_col_meta <= 4'hF;
            r_col_s    <= 4'hF;
        end else begin
            r_col_meta <= key_col;
            r_col_s    <= r_col_meta;
        end
    end

    // Free-running scan divider, cleared only by reset.
    assign w_tick = (r_div == c_DIV_W'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N)
            r_div <= '0;
        else if (w_tick)
            r_div <= '0;
        else
            r_div <= r_div + 1'b1;
    end

    // Exactly one low column is a valid single key; anything else is
    // either idle or a ghost/multi-key pattern.
    always_comb begin
        w_one_low = 1'b1;
        w_col_idx = 2'd0;
        case (r_col_s)
            4'b1110: w_col_idx = 2'd0;
            4'b1101: w_col_idx = 2'd1;
            4'b1011: w_col_idx = 2'd2;
            4'b0111: w_col_idx = 2'd3;
            default: w_one_low = 1'b0;
        endcase
    end

    assign w_deb_inc = r_deb + 1'b1;

    always_comb begin
        w_next_state = r_state;
        w_deb_next   = r_deb;
        w_rotate     = 1'b0;
        w_latch      = 1'b0;
        w_event      = 1'b0;
        case (r_state)
            ST_SCAN: begin
                if (w_tick) begin
                    if (w_one_low) begin
                        w_latch = 1'b1;
                        // With a single required tick the entering tick is
                        // already the accepting one.
                        if (DEB_TICKS == 1) begin
                            w_event      = 1'b1;
                            w_deb_next   = '0;
                            w_next_state = ST_PRESSED;
                        end else begin
                            w_deb_next   = c_DEB_W'(1);
                            w_next_state = ST_DEBOUNCE;
                        end
                    end else begin
                        w_rotate = 1'b1;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (w_tick) begin
                    if (r_col_s == r_col_pat) begin
                        if (w_deb_inc == c_DEB_W'(DEB_TICKS)) begin
                            w_event      = 1'b1;
                            w_deb_next   = '0;
                            w_next_state = ST_PRESSED;
                        end else begin
                            w_deb_next = w_deb_inc;
                        end
                    end else begin
                        w_deb_next   = '0;
                        w_rotate     = 1'b1;
                        w_next_state = ST_SCAN;
                    end
                end
            end
            ST_PRESSED: begin
                if (w_tick) begin
                    if (r_col_s == 4'hF) begin
                        if (w_deb_inc == c_DEB_W'(DEB_TICKS)) begin
                            w_deb_next   = '0;
                            w_rotate     = 1'b1;
                            w_next_state = ST_SCAN;
                        end else begin
                            w_deb_next = w_deb_inc;
                        end
                    end else begin
                        w_deb_next = '0;
                    end
                end
            end
            default: begin
                w_deb_next   = '0;
                w_next_state = ST_SCAN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            r_state   <= ST_SCAN;
            r_deb     <= '0;
            r_row     <= 2'd0;
            r_col_pat <= 4'hF;
            r_col_idx <= 2'd0;
        end else begin
            r_state <= w_next_state;
            r_deb   <= w_deb_next;
            if (w_rotate)
                r_row <= r_row + 1'b1;
            if (w_latch) begin
                r_col_pat <= r_col_s;
                r_col_idx <= w_col_idx;
            end
        end
    end

    // Event column: live in SCAN (single-tick debounce), latched otherwise.
    assign w_evt_col = (r_state == ST_SCAN) ? w_col_idx : r_col_idx;

    always_comb begin
        w_is_digit = 1'b0;
        w_is_back  = 1'b0;
        w_is_enter = 1'b0;
        w_is_clear = 1'b0;
        w_digit    = 4'd0;
        case ({r_row, w_evt_col})
            4'h0: begin w_is_digit = 1'b1; w_digit = 4'd1; end
            4'h1: begin w_is_digit = 1'b1; w_digit = 4'd2; end
            4'h2: begin w_is_digit = 1'b1; w_digit = 4'd3; end
            4'h4: begin w_is_digit = 1'b1; w_digit = 4'd4; end
            4'h5: begin w_is_digit = 1'b1; w_digit = 4'd5; end
            4'h6: begin w_is_digit = 1'b1; w_digit = 4'd6; end
            4'h8: begin w_is_digit = 1'b1; w_digit = 4'd7; end
            4'h9: begin w_is_digit = 1'b1; w_digit = 4'd8; end
            4'hA: begin w_is_digit = 1'b1; w_digit = 4'd9; end
            4'hC: w_is_back  = 1'b1;
            4'hD: begin w_is_digit = 1'b1; w_digit = 4'd0; end
            4'hE: w_is_enter = 1'b1;
            4'hF: w_is_clear = 1'b1;
            default: ;  // A, B, C have no action
        endcase
    end

    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            r_entry  <= 12'h000;
            r_cnt    <= 2'd0;
            r_number <= 12'h000;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_event) begin
                if (w_is_digit && (r_cnt != 2'd3)) begin
                    r_entry <= {r_entry[7:0], w_digit};
                    r_cnt   <= r_cnt + 1'b1;
                end else if (w_is_back && (r_cnt != 2'd0)) begin
                    r_entry <= {4'h0, r_entry[11:4]};
                    r_cnt   <= r_cnt - 1'b1;
                end else if (w_is_enter) begin
                    r_number <= r_entry;
                    r_valid  <= 1'b1;
                    r_entry  <= 12'h000;
                    r_cnt    <= 2'd0;
                end else if (w_is_clear) begin
                    r_entry <= 12'h000;
                    r_cnt   <= 2'd0;
                end
            end
        end
    end

    assign key_row    = ~(4'b0001 << r_row);
    assign entry_BCD  = r_entry;
    assign digit_cnt  = r_cnt;
    assign number_BCD = r_number;
    assign valid      = r_valid;

endmodule
`default_nettype wire
